// File: rtl/an_dec_pkg.sv
// an_dec_pkg: shared types and elaboration-time helpers for the AN-code decoder.
// Holds the FSM state enum, 2^i mod A, the syndrome table builder and its check.
package an_dec_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REDUCE,
    S_CORRECT,
    S_DIVIDE,
    S_DONE
  } state_t;

  localparam int MAX_CW = 32;
  localparam int SW     = 16;

  // Positive syndromes at [i], negative syndromes at [MAX_CW+i].
  typedef logic [2*MAX_CW-1:0][SW-1:0] syn_tbl_t;

  function automatic int pow2_mod(int i, int a);
    int r;
    r = 1 % a;
    for (int k = 0; k < i; k++) r = (2 * r) % a;
    return r;
  endfunction

  function automatic syn_tbl_t build_syn(int cw, int a);
    syn_tbl_t t;
    t = '0;
    for (int i = 0; i < cw && i < MAX_CW; i++) begin
      t[i]          = SW'(pow2_mod(i, a));
      t[MAX_CW + i] = SW'(a - pow2_mod(i, a));
    end
    return t;
  endfunction

  function automatic int syn_idx(int i, int cw);
    return (i < cw) ? i : MAX_CW + i - cw;
  endfunction

  function automatic bit syn_ok(int cw, int a);
    syn_tbl_t t;
    if (a < 3 || (a % 2) == 0) return 1'b0;
    if (cw < 2 || cw > MAX_CW || a >= (1 << SW)) return 1'b0;
    t = build_syn(cw, a);
    for (int i = 0; i < 2 * cw; i++) begin
      if (t[syn_idx(i, cw)] == '0) return 1'b0;
      for (int j = i + 1; j < 2 * cw; j++)
        if (t[syn_idx(i, cw)] == t[syn_idx(j, cw)]) return 1'b0;
    end
    return 1'b1;
  endfunction

endpackage

// File: rtl/an_seq_decoder_if.sv
// an_seq_decoder_if: codeword-in / result-out valid-ready bundle.
// master drives codewords and accepts results; slave is the decoder.
interface an_seq_decoder_if #(
  parameter int CW = 23,
  parameter int DW = 17
);
  localparam int BW = $clog2(CW);

  logic          in_valid;
  logic          in_ready;
  logic [CW-1:0] in_code;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_corrected;
  logic          out_err_neg;
  logic [BW-1:0] out_err_bit;
  logic          out_uncorrectable;

  modport master (
    output in_valid, in_code, out_ready,
    input  in_ready, out_valid, out_data,
    input  out_corrected, out_err_neg,
    input  out_err_bit, out_uncorrectable
  );

  modport slave (
    input  in_valid, in_code, out_ready,
    output in_ready, out_valid, out_data,
    output out_corrected, out_err_neg,
    output out_err_bit, out_uncorrectable
  );
endinterface

// File: rtl/an_seq_divider.sv
// an_seq_divider: CW-cycle restoring divider by the constant A.
// quotient/remainder are valid combinationally in the cycle done is high.
module an_seq_divider #(
  parameter int A  = 47,
  parameter int CW = 23
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [CW-1:0] dividend,
  output logic          done,
  output logic [CW-1:0] quotient,
  output logic [CW-1:0] remainder
);
  localparam int NW = $clog2(CW);
  localparam logic [CW:0] AW = (CW+1)'(A);

  logic          busy_q, busy_d;
  logic [NW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] quo_q, quo_d;
  logic [CW-1:0] rem_q, rem_d;
  logic [CW:0]   trial;
  logic          qbit;

  // one restoring step: shift in next dividend bit, subtract A if it fits
  always_comb begin
    trial = {rem_q, quo_q[CW-1]};
    qbit  = 1'b0;
    if (trial >= AW) begin
      trial = trial - AW;
      qbit  = 1'b1;
    end
    quotient  = {quo_q[CW-2:0], qbit};
    remainder = trial[CW-1:0];
    done      = busy_q && (cnt_q == NW'(CW - 1));
  end

  // load on start, then iterate CW steps
  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    quo_d  = quo_q;
    rem_d  = rem_q;
    if (start) begin
      busy_d = 1'b1;
      cnt_d  = '0;
      quo_d  = dividend;
      rem_d  = '0;
    end else if (busy_q) begin
      quo_d = quotient;
      rem_d = remainder;
      cnt_d = cnt_q + 1'b1;
      if (done) busy_d = 1'b0;
    end
  end

  // divider state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      quo_q  <= '0;
      rem_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      quo_q  <= quo_d;
      rem_q  <= rem_d;
    end
  end
endmodule

// File: rtl/an_seq_decoder.sv
// an_seq_decoder: bit-serial AN-code decoder with single-error correction.
// Define AN_DEC_ERRSTAT_EN to add saturating corrected/uncorrectable counters.
module an_seq_decoder
  import an_dec_pkg::*;
#(
  parameter int A  = 47,
  parameter int CW = 23,
  parameter int DW = 17
) (
  input  logic clk,
  input  logic rst,
  an_seq_decoder_if.slave bus
`ifdef AN_DEC_ERRSTAT_EN
  ,
  output logic [15:0] cnt_corrected,
  output logic [15:0] cnt_uncorrectable
`endif
);
  localparam int RW = $clog2(A) + 1;
  localparam int BW = $clog2(CW);
  localparam int NW = $clog2(CW);
  localparam syn_tbl_t SYN = build_syn(CW, A);
  localparam logic [RW-1:0] AR = RW'(A);

  if (!syn_ok(CW, A)) begin : g_bad_a
    $fatal(1, "an_seq_decoder: A gives zero or duplicate syndromes");
  end

  state_t state_q, state_d;
  logic [CW-1:0] x_q, x_d;
  logic [RW-1:0] r_q, r_d, red;
  logic [NW-1:0] cnt_q, cnt_d;
  logic          ecorr_q, ecorr_d, eneg_q, eneg_d, eunc_q, eunc_d;
  logic [BW-1:0] ebit_q, ebit_d;
  logic [CW:0]   xc;
  logic          hit, cneg;
  logic [BW-1:0] cbit;
  logic          div_done;
  logic [CW-1:0] div_quo, div_rem;
  logic [DW-1:0] data_q, data_d;
  logic          corr_q, corr_d, neg_q, neg_d, unc_q, unc_d, fin_unc;
  logic [BW-1:0] bit_q, bit_d;

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:    if (bus.in_valid) state_d = S_REDUCE;
      S_REDUCE:  if (cnt_q == NW'(CW - 1)) state_d = S_CORRECT;
      S_CORRECT: state_d = S_DIVIDE;
      S_DIVIDE:  if (div_done) state_d = S_DONE;
      S_DONE:    if (bus.out_ready) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // FSM outputs: handshake depends on state only
  always_comb begin
    bus.in_ready  = (state_q == S_IDLE);
    bus.out_valid = (state_q == S_DONE);
  end

  // residue step (2r + bit) mod A and syndrome lookup / correction
  always_comb begin
    red = {r_q[RW-2:0], x_q[NW'(CW - 1) - cnt_q]};
    if (red >= AR) red = red - AR;
    if (red >= AR) red = red - AR;
    hit  = (r_q == '0);
    cneg = 1'b0;
    cbit = '0;
    for (int i = CW - 1; i >= 0; i--) begin
      if (r_q != '0 && r_q == RW'(SYN[MAX_CW + i])) begin
        hit = 1'b1; cneg = 1'b1; cbit = BW'(i);
      end
    end
    for (int i = CW - 1; i >= 0; i--) begin
      if (r_q != '0 && r_q == RW'(SYN[i])) begin
        hit = 1'b1; cneg = 1'b0; cbit = BW'(i);
      end
    end
    xc = {1'b0, x_q};
    if (r_q != '0 && hit) begin
      if (cneg) xc = xc + ((CW+1)'(1) << cbit);
      else      xc = xc - ((CW+1)'(1) << cbit);
    end
  end

  // working registers: capture, reduce, latch correction result
  always_comb begin
    x_d     = x_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    ecorr_d = ecorr_q;
    eneg_d  = eneg_q;
    ebit_d  = ebit_q;
    eunc_d  = eunc_q;
    unique case (1'b1)
      state_q == S_IDLE && bus.in_valid: begin
        x_d   = bus.in_code;
        r_d   = '0;
        cnt_d = '0;
      end
      state_q == S_REDUCE: begin
        r_d   = red;
        cnt_d = cnt_q + 1'b1;
      end
      state_q == S_CORRECT: begin
        ecorr_d = hit && (r_q != '0);
        eneg_d  = cneg;
        ebit_d  = cbit;
        eunc_d  = !hit || xc[CW];
      end
      default: ;
    endcase
  end

  // working register flops
  always_ff @(posedge clk) begin
    if (rst) begin
      x_q     <= '0;
      r_q     <= '0;
      cnt_q   <= '0;
      ecorr_q <= 1'b0;
      eneg_q  <= 1'b0;
      ebit_q  <= '0;
      eunc_q  <= 1'b0;
    end else begin
      x_q     <= x_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
      ecorr_q <= ecorr_d;
      eneg_q  <= eneg_d;
      ebit_q  <= ebit_d;
      eunc_q  <= eunc_d;
    end
  end

  an_seq_divider #(.A(A), .CW(CW)) u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (state_q == S_CORRECT),
    .dividend  (xc[CW-1:0]),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  // result registers load only on the DIVIDE -> DONE transition
  always_comb begin
    data_d  = data_q;
    corr_d  = corr_q;
    neg_d   = neg_q;
    bit_d   = bit_q;
    unc_d   = unc_q;
    fin_unc = eunc_q || (|(div_quo >> DW)) || (|div_rem);
    if (state_q == S_DIVIDE && div_done) begin
      unc_d  = fin_unc;
      data_d = fin_unc ? '0 : DW'(div_quo);
      corr_d = !fin_unc && ecorr_q;
      neg_d  = !fin_unc && eneg_q;
      bit_d  = fin_unc ? '0 : ebit_q;
    end
  end

  // result flops
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
      corr_q <= 1'b0;
      neg_q  <= 1'b0;
      bit_q  <= '0;
      unc_q  <= 1'b0;
    end else begin
      data_q <= data_d;
      corr_q <= corr_d;
      neg_q  <= neg_d;
      bit_q  <= bit_d;
      unc_q  <= unc_d;
    end
  end

  assign bus.out_data          = data_q;
  assign bus.out_corrected     = corr_q;
  assign bus.out_err_neg       = neg_q;
  assign bus.out_err_bit       = bit_q;
  assign bus.out_uncorrectable = unc_q;

`ifdef AN_DEC_ERRSTAT_EN
  logic [15:0] cc_q, cc_d, cu_q, cu_d;

  // saturating counters bump once per output handshake
  always_comb begin
    cc_d = cc_q;
    cu_d = cu_q;
    if (state_q == S_DONE && bus.out_ready) begin
      if (corr_q && cc_q != 16'hFFFF) cc_d = cc_q + 16'd1;
      if (unc_q && cu_q != 16'hFFFF)  cu_d = cu_q + 16'd1;
    end
  end

  // counter flops
  always_ff @(posedge clk) begin
    if (rst) begin
      cc_q <= '0;
      cu_q <= '0;
    end else begin
      cc_q <= cc_d;
      cu_q <= cu_d;
    end
  end

  assign cnt_corrected     = cc_q;
  assign cnt_uncorrectable = cu_q;
`endif
endmodule
